// File: rtl/curr_blk_fetch.sv
// Block-fetch stage: walks one BLKxBLK block of the current-frame memory in raster
// order and presents each pixel through a one-entry valid/ready output register.
//
//   state  | meaning
//   IDLE   | waiting for start_i; read address parked at 0
//   FETCH  | capturing pixels into the output register as it frees up
//   DRAIN  | last pixel captured, waiting for its handshake
module curr_blk_fetch #(
  parameter int IMG_W = 16,
  parameter int BLK   = 4,
  parameter int DW    = 8,
  parameter int AW    = 8,
  localparam int CW   = $clog2(IMG_W / BLK),
  localparam int IW   = $clog2(BLK * BLK)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] blk_x_i,
  input  logic [CW-1:0] blk_y_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] mem_raddr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [DW-1:0] pix_data_o,
  output logic [IW-1:0] pix_idx_o,
  output logic          pix_last_o
);

  localparam int BW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic [BW-1:0] LAST_RC = BW'(BLK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_bx;
  logic [CW-1:0] r_by;
  logic [BW-1:0] r_row;
  logic [BW-1:0] r_col;
  logic          r_busy;
  logic          r_done;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_idx;
  logic          r_last;

  logic [AW-1:0] w_row_abs;
  logic [AW-1:0] w_col_abs;
  logic          w_capture;
  logic          w_last_rc;

  assign w_row_abs   = AW'(r_by) * AW'(BLK) + AW'(r_row);
  assign w_col_abs   = AW'(r_bx) * AW'(BLK) + AW'(r_col);
  assign mem_raddr_o = (r_state == S_IDLE) ? '0 : (w_row_abs * AW'(IMG_W) + w_col_abs);

  // Output register is free when empty or being drained this very edge.
  assign w_capture = !r_valid || pix_ready_i;
  assign w_last_rc = (r_row == LAST_RC) && (r_col == LAST_RC);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_bx    <= '0;
      r_by    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_bx    <= blk_x_i;
            r_by    <= blk_y_i;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_capture) begin
            r_data  <= mem_rdata_i;
            r_idx   <= {r_row, r_col};
            r_last  <= w_last_rc;
            r_valid <= 1'b1;
            if (r_col == LAST_RC) begin
              r_col <= '0;
              r_row <= r_row + BW'(1);
            end else begin
              r_col <= r_col + BW'(1);
            end
            if (w_last_rc) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_valid && pix_ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pix_valid_o = r_valid;
  assign pix_data_o  = r_data;
  assign pix_idx_o   = r_idx;
  assign pix_last_o  = r_last;

endmodule

// File: tb/tb_curr_blk_fetch.sv
// Directed plus randomized bench for curr_blk_fetch; expected pixels come from a
// queue built directly from the block coordinates and the memory image.
module tb_curr_blk_fetch;

  localparam int IMG_W = 16;
  localparam int BLK   = 4;
  localparam int NPIX  = BLK * BLK;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [1:0] blk_x_i = '0;
  logic [1:0] blk_y_i = '0;
  logic       busy_o;
  logic       done_o;
  logic [7:0] mem_raddr_o;
  logic [7:0] mem_rdata_i;
  logic       pix_valid_o;
  logic       pix_ready_i = 1'b0;
  logic [7:0] pix_data_o;
  logic [3:0] pix_idx_o;
  logic       pix_last_o;

  logic [7:0] mem [256];
  assign mem_rdata_i = mem[mem_raddr_o];

  int n_checks = 0;
  int n_errors = 0;

  curr_blk_fetch dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .blk_x_i     (blk_x_i),
    .blk_y_i     (blk_y_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_rdata_i (mem_rdata_i),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .pix_data_o  (pix_data_o),
    .pix_idx_o   (pix_idx_o),
    .pix_last_o  (pix_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,1,..., 2: random ready.
  // abort_n < NPIX stops after that many transfers (used for the reset test).
  task automatic run_block(input int bx, input int by, input int mode,
                           input bit inj_start, input int abort_n);
    logic [7:0] exp_q [$];
    int         n;
    int         cyc;
    bit         stalled;
    logic [7:0] h_data;
    logic [3:0] h_idx;
    logic       h_last;
    bit         rdy;

    exp_q.delete();
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        exp_q.push_back(mem[(by * BLK + r) * IMG_W + bx * BLK + c]);

    start_i = 1'b1;
    blk_x_i = 2'(bx);
    blk_y_i = 2'(by);
    step();
    start_i = 1'b0;
    chk("busy_k1", busy_o, 1);
    chk("valid_k1", pix_valid_o, 0);
    pix_ready_i = 1'b0;
    step();
    chk("valid_k2", pix_valid_o, 1);
    chk("first_pix", pix_data_o, exp_q[0]);
    chk("first_idx", pix_idx_o, 0);

    n = 0;
    cyc = 0;
    stalled = 0;
    h_data = '0;
    h_idx = '0;
    h_last = 1'b0;
    while (n < abort_n && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      pix_ready_i = rdy;
      start_i = inj_start && (cyc == 3);
      if (start_i) begin
        blk_x_i = 2'd2;
        blk_y_i = 2'd2;
      end
      chk("valid_held", pix_valid_o, 1);
      chk("busy_held", busy_o, 1);
      if (stalled) begin
        chk("stall_data", pix_data_o, h_data);
        chk("stall_idx", pix_idx_o, h_idx);
        chk("stall_last", pix_last_o, h_last);
      end
      if (rdy) begin
        chk("beat_data", pix_data_o, exp_q[n]);
        chk("beat_idx", pix_idx_o, n);
        chk("beat_last", pix_last_o, (n == NPIX - 1));
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
        h_data = pix_data_o;
        h_idx = pix_idx_o;
        h_last = pix_last_o;
      end
      step();
      cyc++;
    end
    start_i = 1'b0;
    pix_ready_i = 1'(($urandom_range(0, 1)));
    chk("beat_count", n, abort_n);
    if (abort_n < NPIX) return;
    if (mode == 0) chk("full_rate_cycles", cyc, NPIX);
    chk("done_pulse", done_o, 1);
    chk("busy_done", busy_o, 0);
    chk("valid_done", pix_valid_o, 0);
  endtask

  task automatic idle_step();
    step();
    chk("done_once", done_o, 0);
    chk("busy_idle", busy_o, 0);
    chk("addr_idle", mem_raddr_o, 0);
    chk("valid_idle", pix_valid_o, 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);

    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", pix_valid_o, 0);
    chk("rst_data", pix_data_o, 0);
    chk("rst_idx", pix_idx_o, 0);
    chk("rst_last", pix_last_o, 0);
    chk("rst_addr", mem_raddr_o, 0);
    rst_i = 1'b0;
    step();

    run_block(0, 0, 0, 0, NPIX);
    idle_step();
    run_block(3, 3, 0, 0, NPIX);
    idle_step();
    run_block(1, 2, 1, 0, NPIX);
    idle_step();
    run_block(0, 0, 0, 1, NPIX);
    idle_step();

    run_block(1, 1, 0, 0, 5);
    rst_i = 1'b1;
    #2;
    chk("arst_valid", pix_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_addr", mem_raddr_o, 0);
    chk("arst_idx", pix_idx_o, 0);
    step();
    rst_i = 1'b0;
    step();
    run_block(1, 2, 0, 0, NPIX);
    idle_step();

    run_block(0, 0, 0, 0, NPIX);
    run_block(1, 0, 0, 0, NPIX);
    idle_step();

    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, 0, NPIX);
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    idle_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/curr_blk_fetch.md
Name: curr_blk_fetch

Overview:
Block-fetch stage directly downstream of the current-frame image memory (16x16 pixels, 8-bit, combinational read port). On a start command it walks one BLKxBLK block of the image in raster order, drives the memory read address, and registers each pixel into a one-entry valid/ready output stage that feeds the block-matching/SAD datapath. It runs at full throughput (one pixel per cycle) when the consumer is ready, and stalls cleanly under backpressure.

Parameters:
IMG_W, 16, image width and height in pixels; must be a multiple of BLK; IMG_W*IMG_W <= 2^AW
BLK, 4, block edge in pixels; power of two
DW, 8, pixel width
AW, 8, memory address width
CW, $clog2(IMG_W/BLK) (=2), block-coordinate width (derived)

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  request a block fetch; sampled only when busy_o=0
blk_x_i  in  CW  block column index, latched on accepted start
blk_y_i  in  CW  block row index, latched on accepted start
busy_o  out  1  high from the cycle after an accepted start until the done cycle
done_o  out  1  one-cycle pulse after the last pixel handshake
mem_raddr_o  out  AW  read address to the image memory
mem_rdata_i  in  DW  combinational read data for mem_raddr_o
pix_valid_o  out  1  output pixel valid
pix_ready_i  in  1  consumer ready
pix_data_o  out  DW  registered pixel
pix_idx_o  out  $clog2(BLK*BLK) (=4)  in-block index row*BLK+col of the presented pixel
pix_last_o  out  1  high with the final pixel (index BLK*BLK-1)

Behaviour:
- Reset (async, any time including mid-stream): FSM=IDLE, busy_o=0, done_o=0, pix_valid_o=0, pix_data_o=0, pix_idx_o=0, pix_last_o=0, mem_raddr_o=0, counters and latched coordinates=0. No partial stream resumes after reset.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: start_i=1 at an edge latches blk_x_i/blk_y_i, clears the fetch counter (row r, col c), and moves to FETCH. start_i while busy_o=1 is ignored, with no effect on the latched coordinates.
- Address: mem_raddr_o = (blk_y*BLK + r)*IMG_W + blk_x*BLK + c, computed from registers. It reads as 0 in IDLE.
- Capture condition in FETCH: (pix_valid_o=0 or pix_ready_i=1). When true, at the edge:
  - pix_data_o <= mem_rdata_i
  - pix_idx_o <= r*BLK+c
  - pix_last_o <= (r=c=BLK-1)
  - pix_valid_o <= 1
  - the counter advances raster-order (c wraps to 0 and r increments)
- After capturing the last pixel, the FSM goes to DRAIN and stops issuing captures.
- Handshake: a beat transfers on an edge with pix_valid_o=1 and pix_ready_i=1. While pix_valid_o=1 and pix_ready_i=0, pix_data_o, pix_idx_o and pix_last_o hold stable. pix_valid_o never drops without a transfer.
- DRAIN: on the transfer of the last pixel, pix_valid_o <= 0, done_o <= 1 for one cycle, busy_o <= 0, and FSM goes to IDLE. In the same cycle, pix_valid_o clears to 0, so no bubble is produced and no pixel is duplicated.
- Latency: start_i high in cycle k gives busy_o=1 in k+1 and pix_valid_o=1 with pixel 0 in k+2. With pix_ready_i held at 1, the block takes BLK*BLK consecutive beats, and done_o is high in cycle k+2+BLK*BLK.
- Back-to-back: start_i asserted in the done_o cycle is accepted (busy_o=0 there).
- Memory writes landing during a fetch are not coherent; the block returns whatever the memory presents at capture time.

Test Plan:
- Memory preloaded with mem[a]=a. Start (x=0,y=0), pix_ready_i=1 -> 16 consecutive beats with data 00,01,02,03,10,11,12,13,20..23,30..33; pix_idx_o 0..15; pix_last_o only on 0x33; done_o pulses in the cycle after, then busy_o=0.
- Start (3,3), pix_ready_i=1 -> data CC,CD,CE,CF,DC..DF,EC..EF,FC..FF; last on FF; no address overflow.
- Start (1,2), pix_ready_i toggling 1,0,1,0 -> data held stable in every stalled cycle; exactly 16 transfers 84..87,94..97,A4..A7,B4..B7; none skipped or duplicated.
- During the (0,0) stream, pulse start_i with (2,2) -> ignored; the stream completes as 00..33; done_o fires once.
- Assert rst_i after 5 transfers of (1,1) -> pix_valid_o, busy_o and mem_raddr_o are 0 immediately. Then start (1,2) -> first pixel 0x84 two cycles after start, with pix_idx_o=0.
- Assert start_i with (1,0) in the done_o cycle of a (0,0) fetch -> accepted; the first pixel 0x04 appears two cycles later.
